// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one CombDivider8 among NUM_REQ valid/ready requesters.
// Optional `DIVIDER_ARB_DBZ_EN: zero divisor bypasses the divider and flags rsp_dbz.
module divider_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_lop,
    input  logic [NUM_REQ*8-1:0] req_rop,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_quot,
    output logic [7:0]           rsp_mod,
    output logic                 rsp_dbz,
    output logic [1:0]           dbg_state
);
    // Handshake: a request transfers on the cycle req_valid[i] && req_ready[i];
    // a response transfers on the cycle rsp_valid && rsp_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, winner, op_id;
    logic            any_valid, grant;
    logic [7:0]      sel_lop, sel_rop, op_lop, op_rop;
    logic [7:0]      div_quot, div_mod, cap_quot, cap_mod;
    logic            cap_dbz;
    logic [7:0]      quot_q, mod_q;
    logic            dbz_q;

    // Descending scan so the requester closest to rr_ptr is the last to overwrite.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        sel_lop   = '0;
        sel_rop   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (req_valid[idx]) begin
                winner    = ID_W'(idx);
                any_valid = 1'b1;
                sel_lop   = req_lop[idx*8 +: 8];
                sel_rop   = req_rop[idx*8 +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready[winner] = 1'b1;
                    grant             = 1'b1;
                    state_nxt         = BUSY;
                end
            end
            BUSY:    state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    CombDivider8 u_div (
        .lop  (op_lop),
        .rop  (op_rop),
        .quot (div_quot),
        .mod  (div_mod)
    );

`ifdef DIVIDER_ARB_DBZ_EN
    always_comb begin
        cap_quot = div_quot;
        cap_mod  = div_mod;
        cap_dbz  = 1'b0;
        if (op_rop == 8'd0) begin
            cap_quot = 8'hFF;
            cap_mod  = op_lop;
            cap_dbz  = 1'b1;
        end
    end
`else
    assign cap_quot = div_quot;
    assign cap_mod  = div_mod;
    assign cap_dbz  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            op_lop <= '0;
            op_rop <= '0;
            op_id  <= '0;
            quot_q <= '0;
            mod_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                op_lop <= sel_lop;
                op_rop <= sel_rop;
                op_id  <= winner;
                rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
            end
            if (state == BUSY) begin
                quot_q <= cap_quot;
                mod_q  <= cap_mod;
                dbz_q  <= cap_dbz;
            end
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_id    = op_id;
    assign rsp_quot  = quot_q;
    assign rsp_mod   = mod_q;
    assign rsp_dbz   = dbz_q;
    assign dbg_state = state;

endmodule

// Unsigned 8-bit restoring divider; a zero divisor yields quot=8'hFF, mod=lop.
module CombDivider8 (
    input  logic [7:0] lop,
    input  logic [7:0] rop,
    output logic [7:0] quot,
    output logic [7:0] mod
);
    logic [8:0] rem;

    always_comb begin
        rem  = '0;
        quot = '0;
        for (int i = 7; i >= 0; i--) begin
            rem = {rem[7:0], lop[i]};
            if (rem >= {1'b0, rop}) begin
                rem     = rem - {1'b0, rop};
                quot[i] = 1'b1;
            end
        end
        mod = rem[7:0];
    end
endmodule

// File: tb/tb_divider_arbiter.sv
// Randomized bench for divider_arbiter against a transaction-level round-robin/division model.
module tb_divider_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int RSP_W   = ID_W + 17;
`ifdef DIVIDER_ARB_DBZ_EN
    localparam bit DBZ     = 1'b1;
    localparam int MIN_ROP = 0;
`else
    localparam bit DBZ     = 1'b0;
    localparam int MIN_ROP = 1;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_lop = '0;
    logic [NUM_REQ*8-1:0] req_rop = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_quot, rsp_mod;
    logic                 rsp_dbz;
    logic [1:0]           dbg_state;

    divider_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_lop(req_lop),
        .req_rop(req_rop), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_quot(rsp_quot),
        .rsp_mod(rsp_mod), .rsp_dbz(rsp_dbz), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int                 checks = 0;
    int                 errors = 0;
    logic [RSP_W-1:0]   exp_q[$];
    logic [NUM_REQ-1:0] pend;
    logic [7:0]         lop_a[NUM_REQ];
    logic [7:0]         rop_a[NUM_REQ];
    int                 ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RSP_W-1:0] model_rsp(input int id);
        logic [7:0] q, m;
        logic       d;
        if (rop_a[id] == 8'd0) begin
            q = 8'hFF; m = lop_a[id]; d = DBZ;
        end else begin
            q = lop_a[id] / rop_a[id]; m = lop_a[id] % rop_a[id]; d = 1'b0;
        end
        return {ID_W'(id), q, m, d};
    endfunction

    function automatic int model_winner();
        for (int off = 0; off < NUM_REQ; off++)
            if (pend[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
        return -1;
    endfunction

    task automatic new_op(input int i);
        lop_a[i] = 8'($urandom_range(0, 255));
        rop_a[i] = 8'($urandom_range(MIN_ROP, 255));
    endtask

    task automatic set_op(input int i, input int a, input int b);
        lop_a[i] = 8'(a);
        rop_a[i] = 8'(b);
        pend[i]  = 1'b1;
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]       = pend[i];
            req_lop[8*i +: 8]  = lop_a[i];
            req_rop[8*i +: 8]  = rop_a[i];
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        pend      = '0;
        rsp_ready = 1'b0;
        apply();
        @(negedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp", {rsp_valid, rsp_id, rsp_quot, rsp_mod, rsp_dbz}, 0);
        reset_n = 1'b1;
        ptr     = 0;
        exp_q.delete();
    endtask

    // Entered and left at a negedge with the DUT idle; pend must be nonzero.
    task automatic txn(input int bp, input bit refill, input bit churn, input logic [NUM_REQ-1:0] add);
        int               w;
        logic [RSP_W-1:0] e;
        apply();
        #2;
        w = model_winner();
        if (w < 0) return;
        check("grant", 32'(req_ready), 32'(1 << w));
        check("rsp_valid_idle", 32'(rsp_valid), 0);
        exp_q.push_back(model_rsp(w));
        ptr = (w + 1) % NUM_REQ;
        @(negedge clk);
        pend[w] = refill;
        if (refill) new_op(w);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (add[i] && !pend[i]) begin pend[i] = 1'b1; new_op(i); end
            if (churn && i != w && $urandom_range(0, 3) == 0) begin
                pend[i] = ~pend[i];
                if (pend[i]) new_op(i);
            end
        end
        apply();
        rsp_ready = 1'($urandom_range(0, 1));
        #2;
        check("busy_req_ready", 32'(req_ready), 0);
        check("busy_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        e = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_id", 32'(rsp_id), 32'(e[RSP_W-1 -: ID_W]));
        check("rsp_quot", 32'(rsp_quot), 32'(e[16:9]));
        check("rsp_mod", 32'(rsp_mod), 32'(e[8:1]));
        check("rsp_dbz", 32'(rsp_dbz), 32'(e[0]));
        check("done_req_ready", 32'(req_ready), 0);
        for (int k = 0; k < bp; k++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check("hold_rsp", {rsp_valid, rsp_id, rsp_quot, rsp_mod, rsp_dbz}, {1'b1, e});
            check("hold_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'($urandom_range(0, 1));
        check("after_accept_rsp_valid", 32'(rsp_valid), 0);
    endtask

    task automatic idle(input int n);
        pend = '0;
        apply();
        for (int k = 0; k < n; k++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            #2;
            check("idle_req_ready", 32'(req_ready), 0);
            check("idle_rsp_valid", 32'(rsp_valid), 0);
            @(negedge clk);
        end
    endtask

    task automatic reset_in_busy();
        int w;
        pend = '0;
        set_op(0, 9, 2);
        txn(0, 1'b0, 1'b0, '0);
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 60 + i, 7);
        apply();
        #2;
        w = model_winner();
        check("rib_grant", 32'(req_ready), 32'(1 << w));
        @(negedge clk);
        pend[w] = 1'b0;
        apply();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ptr     = 0;
        check("rib_rsp_cleared", {rsp_valid, rsp_id, rsp_quot, rsp_mod, rsp_dbz}, 0);
        #2;
        check("rib_lowest_grant", 32'(req_ready), 32'(1 << model_winner()));
        while (pend != '0) txn(0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        pend = '0;
        ptr  = 0;
        for (int i = 0; i < NUM_REQ; i++) new_op(i);
        do_reset();

        set_op(0, 45, 13);
        txn(0, 1'b0, 1'b0, '0);

        do_reset();
        set_op(0, 5, 3); set_op(1, 20, 5); set_op(2, 45, 13); set_op(3, 200, 7);
        for (int t = 0; t < NUM_REQ; t++) txn(0, 1'b0, 1'b0, '0);

        do_reset();
        set_op(1, 17, 4);
        txn(0, 1'b0, 1'b0, '0);
        set_op(1, 99, 9); set_op(3, 250, 16);
        for (int t = 0; t < 4; t++) txn(0, 1'b1, 1'b0, '0);
        idle(1);

        set_op(0, 77, 6);
        txn(5, 1'b0, 1'b0, 4'b0100);
        txn(0, 1'b0, 1'b0, '0);

        reset_in_busy();

`ifdef DIVIDER_ARB_DBZ_EN
        set_op(0, 20, 0);
        txn(0, 1'b0, 1'b0, '0);
        set_op(0, 20, 5);
        txn(0, 1'b0, 1'b0, '0);
`endif

        for (int r = 0; r < 60; r++) begin
            if (pend == '0) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                pend = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
                for (int i = 0; i < NUM_REQ; i++) if (pend[i]) new_op(i);
            end
            txn($urandom_range(0, 3), 1'b0, 1'b1, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
